chip_test_ctrl: RTL

- Front-end sequencer that sits directly upstream of the per-chip tester blocks (quad-gate checkers with a Run / Done / RSLT / DISP_RSLT handshake).
- Debounces the user Start button and latches the chip-select switches.
- Launches the selected tester with a one-cycle Run pulse, waits for its Done, captures RSLT, acknowledges with DISP_RSLT, and holds a Pass / Fail / Timeout verdict for the display logic until the next test.

---
 rtl/chip_test_pkg.sv | 15 +
 rtl/button_debounce.sv | 46 ++++
 rtl/chip_test_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chip_test_pkg.sv
// Shared types and default timing constants for the chip test sequencer.
package chip_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    ACK,
    SHOW
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int TIMEOUT_CYCLES_DEF  = 1024;

endpackage

// File: rtl/button_debounce.sv
// Front-panel button conditioner: 2-flop synchroniser, saturating run-length
// counter and a single press pulse per accepted press.
module button_debounce
  import chip_test_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1]) begin
      // Saturation keeps a held button from producing a second pulse.
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      press_d = (cnt_q == CNT_MAX - CNT_W'(1));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/chip_test_ctrl.sv
// Sequencer that launches the selected chip tester, waits for its Done and
// holds a Pass / Fail / Timeout verdict for the display.
//
// state     | meaning
// IDLE      | after reset, waiting for a press
// LAUNCH    | Run pulse to the latched tester, timeout counter cleared
// WAIT_DONE | counting towards timeout, watching the latched tester's Done
// ACK       | DISP_RSLT to the tester, verdict loaded from captured RSLT
// SHOW      | verdict held, a new press restarts
module chip_test_ctrl
  import chip_test_pkg::*;
#(
  parameter int NUM_CHIPS       = 4,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [SEL_W-1:0]     ChipSel,
  input  logic [NUM_CHIPS-1:0] Done_vec,
  input  logic [NUM_CHIPS-1:0] RSLT_vec,
  output logic [NUM_CHIPS-1:0] Run_vec,
  output logic                 DISP_RSLT,
  output logic                 Busy,
  output logic                 Pass,
  output logic                 Fail,
  output logic                 Timeout,
  output logic [SEL_W-1:0]     ActiveSel
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_CHIPS_L = (SEL_W + 1)'(NUM_CHIPS);

  state_e          state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             rslt_q, rslt_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             tmo_q, tmo_d;
  logic             press;
  logic             sel_in_range;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .Clk    (Clk),
    .Reset  (Reset),
    .btn_raw(Start),
    .press  (press)
  );

  assign sel_in_range = ({1'b0, ChipSel} < NUM_CHIPS_L);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    to_cnt_d = to_cnt_q;
    rslt_d   = rslt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE, SHOW: begin
        if (press) begin
          sel_d  = ChipSel;
          pass_d = 1'b0;
          fail_d = 1'b0;
          tmo_d  = 1'b0;
          if (sel_in_range) begin
            state_d = LAUNCH;
          end else begin
            state_d = SHOW;
            fail_d  = 1'b1;
          end
        end
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Done is checked first so it wins on the terminal-count cycle.
        if (Done_vec[sel_q]) begin
          rslt_d  = RSLT_vec[sel_q];
          state_d = ACK;
        end else if (to_cnt_q == TO_LAST) begin
          tmo_d   = 1'b1;
          state_d = SHOW;
        end
      end
      ACK: begin
        pass_d  = rslt_q;
        fail_d  = ~rslt_q;
        state_d = SHOW;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      to_cnt_q <= '0;
      rslt_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      to_cnt_q <= to_cnt_d;
      rslt_q   <= rslt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
    end
  end

  // Handshake outputs decode straight from the state so reset drops them at once.
  always_comb begin
    Run_vec = '0;
    if (state_q == LAUNCH) Run_vec[sel_q] = 1'b1;
  end

  assign DISP_RSLT = (state_q == ACK);
  assign Busy      = (state_q == LAUNCH) || (state_q == WAIT_DONE) || (state_q == ACK);
  assign Pass      = pass_q;
  assign Fail      = fail_q;
  assign Timeout   = tmo_q;
  assign ActiveSel = sel_q;

endmodule
